// File: rtl/mac_result_serializer.sv
// Buffers accumulator results in a small FIFO and streams them out LSB byte first.
// Define SER_CHECKSUM_EN to append an XOR checksum beat to every word.
module mac_result_serializer #(
  parameter int ACC_W = 24,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [ACC_W-1:0] acc_data,
  input  logic             acc_valid,
  output logic             acc_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [7:0]       words_sent
);

  localparam int NDB = ACC_W / 8;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [1:0] LAST_IDX = 2'(NDB - 1);

`ifdef SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;

  function automatic logic [7:0] xsum(input logic [ACC_W-1:0] w);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < NDB; i++) s = s ^ w[i*8 +: 8];
    return s;
  endfunction
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t           state, nxt_state;
  logic [ACC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, nxt_rd, nxt_wr;
  logic [CW-1:0]    count, nxt_count;
  logic [1:0]       idx, nxt_idx;
  logic             push, pop, beat;
  logic [ACC_W-1:0] nxt_head;

  always_comb begin
    push      = acc_valid && acc_ready && !clr;
    beat      = out_valid && out_ready && !clr;
    pop       = 1'b0;
    nxt_state = state;
    nxt_idx   = idx;
    case (state)
      IDLE: if (count != '0) nxt_state = SEND;
      SEND: if (beat) begin
        if (idx == LAST_IDX) begin
`ifdef SER_CHECKSUM_EN
          nxt_state = CHK;
`else
          pop = 1'b1;
`endif
          nxt_idx = '0;
        end else begin
          nxt_idx = idx + 2'd1;
        end
      end
`ifdef SER_CHECKSUM_EN
      CHK: if (beat) pop = 1'b1;
`endif
      default: nxt_state = IDLE;
    endcase
    nxt_count = count + CW'(push) - CW'(pop);
    nxt_rd    = pop  ? rd_ptr + 1'b1 : rd_ptr;
    nxt_wr    = push ? wr_ptr + 1'b1 : wr_ptr;
    if (pop) nxt_state = (nxt_count != '0) ? SEND : IDLE;
    if (clr) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
      nxt_count = '0;
      nxt_rd    = '0;
      nxt_wr    = '0;
    end
    // A word written this cycle can become the head right after a pop
    nxt_head = (push && wr_ptr == nxt_rd) ? acc_data : mem[nxt_rd];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= acc_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      acc_ready  <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_byte   <= '0;
      words_sent <= '0;
    end else begin
      state     <= nxt_state;
      idx       <= nxt_idx;
      count     <= nxt_count;
      rd_ptr    <= nxt_rd;
      wr_ptr    <= nxt_wr;
      acc_ready <= (nxt_count < CW'(DEPTH));
      out_valid <= (nxt_state != IDLE);
      if (pop) words_sent <= words_sent + 8'd1;
      case (nxt_state)
        SEND: begin
          out_byte <= nxt_head[{nxt_idx, 3'b000} +: 8];
`ifdef SER_CHECKSUM_EN
          out_last <= 1'b0;
`else
          out_last <= (nxt_idx == LAST_IDX);
`endif
        end
`ifdef SER_CHECKSUM_EN
        CHK: begin
          out_byte <= xsum(nxt_head);
          out_last <= 1'b1;
        end
`endif
        default: begin
          out_byte <= '0;
          out_last <= 1'b0;
        end
      endcase
    end
  end

endmodule
